pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core pipeline (IF, ID, EX, MEM, WB). Each cycle it produces the enable and clear strobes for the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, EX-stage redirects, multi-cycle EX operations and MEM-stage wait states. It is the only block that drives the `enable`/`clr` inputs of the pipeline flip-flops.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_ctrl_mc_countdown.sv | 28 ++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states and the strobe bundle.
package pipe_pkg;

  localparam int LAT_W_DEF = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pipe_state_t;

  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic clr_ifid;
    logic clr_idex;
    logic clr_exmem;
    logic clr_memwb;
  } strobes_t;

  localparam strobes_t STB_DEFAULT = 9'b1_1111_0000;
  localparam strobes_t STB_RESET   = 9'b0_0000_1111;

endpackage

// File: rtl/pipe_ctrl_mc_countdown.sv
// Multi-cycle op countdown: load, saturating decrement, end-of-op flag.
// o_zero means the count reaches zero at the coming edge, so the current cycle is the capture cycle.
module mc_countdown #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt <= W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller; strobes are combinational (0-cycle) from state and hazards.
// Optional stall-cycle counter and stall_cnt port with PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ld_hazard,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic [LAT_W-1:0] ex_mc_lat,
  input  logic             mem_stall,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             clr_ifid,
  output logic             clr_idex,
  output logic             clr_exmem,
  output logic             clr_memwb
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;
  strobes_t    w_stb;
  logic        w_enter;
  logic        w_busy;
  logic        w_zero;

  assign w_enter = (r_state == RUN) && ex_mc_start && (ex_mc_lat >= LAT_W'(2)) && !mem_stall;
  assign w_busy  = (r_state == MC_WAIT) && !w_zero;

  mc_countdown #(
    .W(LAT_W)
  ) u_mc_countdown (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_enter),
    .i_load_val(ex_mc_lat - LAT_W'(1)),
    .i_dec     (r_state == MC_WAIT),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_stb       = STB_DEFAULT;
    w_state_nxt = r_state;

    if (rst) begin
      w_stb = STB_RESET;
    end else if (mem_stall) begin
      w_stb.en_pc     = 1'b0;
      w_stb.en_ifid   = 1'b0;
      w_stb.en_idex   = 1'b0;
      w_stb.en_exmem  = 1'b0;
      w_stb.clr_memwb = 1'b1;
    end else if (w_enter || w_busy) begin
      // EX still computing: hold front end, drain MEM/WB, feed EX/MEM bubbles
      w_stb.en_pc     = 1'b0;
      w_stb.en_ifid   = 1'b0;
      w_stb.en_idex   = 1'b0;
      w_stb.clr_exmem = 1'b1;
      w_stb.en_memwb  = 1'b1;
    end else if (ex_redirect) begin
      w_stb.en_pc    = 1'b1;
      w_stb.clr_ifid = 1'b1;
      w_stb.clr_idex = 1'b1;
    end else if (id_ld_hazard) begin
      w_stb.en_pc    = 1'b0;
      w_stb.en_ifid  = 1'b0;
      w_stb.clr_idex = 1'b1;
    end

    case (r_state)
      RUN:     if (w_enter) w_state_nxt = MC_WAIT;
      MC_WAIT: if (w_zero && !mem_stall) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  assign en_pc     = w_stb.en_pc;
  assign en_ifid   = w_stb.en_ifid;
  assign en_idex   = w_stb.en_idex;
  assign en_exmem  = w_stb.en_exmem;
  assign en_memwb  = w_stb.en_memwb;
  assign clr_ifid  = w_stb.clr_ifid;
  assign clr_idex  = w_stb.clr_idex;
  assign clr_exmem = w_stb.clr_exmem;
  assign clr_memwb = w_stb.clr_memwb;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!w_stb.en_pc) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, multi-cycle sequences, randomized run vs a cycle-count model.
module tb_pipe_ctrl;

  localparam logic [8:0] E_DEF   = 9'b1_1111_0000;
  localparam logic [8:0] E_RST   = 9'b0_0000_1111;
  localparam logic [8:0] E_MEM   = 9'b0_0001_0001;
  localparam logic [8:0] E_MC    = 9'b0_0011_0010;
  localparam logic [8:0] E_REDIR = 9'b1_1111_1100;
  localparam logic [8:0] E_HAZ   = 9'b0_0111_0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_ld_hazard = 1'b0;
  logic       ex_redirect = 1'b0;
  logic       ex_mc_start = 1'b0;
  logic [4:0] ex_mc_lat = '0;
  logic       mem_stall = 1'b0;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic clr_ifid, clr_idex, clr_exmem, clr_memwb;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_ld_hazard(id_ld_hazard),
    .ex_redirect (ex_redirect),
    .ex_mc_start (ex_mc_start),
    .ex_mc_lat   (ex_mc_lat),
    .mem_stall   (mem_stall),
    .en_pc       (en_pc),
    .en_ifid     (en_ifid),
    .en_idex     (en_idex),
    .en_exmem    (en_exmem),
    .en_memwb    (en_memwb),
    .clr_ifid    (clr_ifid),
    .clr_idex    (clr_idex),
    .clr_exmem   (clr_exmem),
    .clr_memwb   (clr_memwb)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  wire [8:0] dut_vec = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                        clr_ifid, clr_idex, clr_exmem, clr_memwb};

  int n_tot  = 0;
  int n_pass = 0;

  // Reference model: whether a multi-cycle op is in flight, how many cycles
  // have elapsed since it was accepted, and its latency.
  bit          m_mc = 1'b0;
  int          m_k = 0;
  int          m_L = 0;
  int unsigned m_stall = 0;

  typedef struct {
    logic       r, ldh, red, mcs;
    logic [4:0] lat;
    logic       mem;
    logic [8:0] exp;
    string      nm;
  } vec_t;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: strobes got %b expected %b", nm, act, exp);
  endtask

  function automatic logic [8:0] model_exp(input logic r, ldh, red, mcs,
                                           input logic [4:0] lat, input logic mem);
    bit blocked;
    blocked = (!m_mc && mcs && (lat >= 2) && !mem) || (m_mc && (m_k < m_L - 1));
    if (r) return E_RST;
    if (mem) return E_MEM;
    if (blocked) return E_MC;
    if (red) return E_REDIR;
    if (ldh) return E_HAZ;
    return E_DEF;
  endfunction

  task automatic model_step(input logic r, mcs, input logic [4:0] lat, input logic mem,
                            input logic [8:0] exp);
    if (r) begin
      m_mc = 1'b0;
      m_stall = 0;
    end else begin
      if (!exp[8]) m_stall++;
      if (!m_mc) begin
        if (mcs && lat >= 2 && !mem) begin
          m_mc = 1'b1;
          m_k = 1;
          m_L = int'(lat);
        end
      end else if (m_k >= m_L - 1 && !mem) begin
        m_mc = 1'b0;
      end else begin
        m_k++;
      end
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance the model at posedge.
  task automatic cyc(input logic r, ldh, red, mcs, input logic [4:0] lat, input logic mem,
                     input logic [8:0] exp, input string nm);
    rst = r; id_ld_hazard = ldh; ex_redirect = red;
    ex_mc_start = mcs; ex_mc_lat = lat; mem_stall = mem;
    @(negedge clk);
    chk(nm, dut_vec, exp);
`ifdef PIPE_CTRL_PERF_EN
    if (!r) begin
      n_tot++;
      if (stall_cnt === m_stall) n_pass++;
      else $display("FAIL %s stall_cnt: got %0d expected %0d", nm, stall_cnt, m_stall);
    end
`endif
    @(posedge clk);
    model_step(r, mcs, lat, mem, model_exp(r, ldh, red, mcs, lat, mem));
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 5'd0, 0, E_DEF,   "idle"};
    tbl[1]  = '{0, 1, 0, 0, 5'd0, 0, E_HAZ,   "load_use"};
    tbl[2]  = '{0, 0, 1, 0, 5'd0, 0, E_REDIR, "redirect"};
    tbl[3]  = '{0, 1, 1, 0, 5'd0, 0, E_REDIR, "redirect_beats_hazard"};
    tbl[4]  = '{0, 0, 0, 0, 5'd0, 1, E_MEM,   "mem_stall"};
    tbl[5]  = '{0, 1, 0, 0, 5'd0, 1, E_MEM,   "mem_over_hazard"};
    tbl[6]  = '{0, 0, 1, 0, 5'd0, 1, E_MEM,   "mem_over_redirect"};
    tbl[7]  = '{1, 1, 1, 1, 5'd4, 1, E_RST,   "reset_over_all"};
    tbl[8]  = '{0, 0, 0, 1, 5'd0, 0, E_DEF,   "mc_lat0_single"};
    tbl[9]  = '{0, 0, 0, 1, 5'd1, 0, E_DEF,   "mc_lat1_single"};
    tbl[10] = '{0, 0, 0, 1, 5'd4, 1, E_MEM,   "mc_blocked_by_mem"};
    tbl[11] = '{0, 1, 0, 1, 5'd1, 0, E_HAZ,   "mc_lat1_with_hazard"};

    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 5'd0, 0, E_RST, "reset");
    cyc(1, 0, 0, 0, 5'd0, 0, E_RST, "reset");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "idle10");

    cyc(0, 1, 0, 0, 5'd0, 0, E_HAZ, "hazard_once");
    cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "after_hazard");

    for (int i = 0; i < 12; i++)
      cyc(tbl[i].r, tbl[i].ldh, tbl[i].red, tbl[i].mcs, tbl[i].lat, tbl[i].mem,
          tbl[i].exp, tbl[i].nm);
    cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "post_table");

    // Latency 4: three blocked cycles, capture on the fourth.
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 1, 5'd4, 0, E_MC, "mc4_block");
    cyc(0, 0, 0, 1, 5'd4, 0, E_DEF, "mc4_capture");
    cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "mc4_run");

    // Latency 3 overlapped by mem_stall on cycles 2-5.
    cyc(0, 0, 0, 1, 5'd3, 0, E_MC, "mc3_entry");
    for (int i = 2; i <= 5; i++) cyc(0, 0, 0, 1, 5'd3, 1, E_MEM, "mc3_memstall");
    cyc(0, 0, 0, 1, 5'd3, 0, E_DEF, "mc3_release");
    cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "mc3_run");

    // Latency 7, reset while five cycles remain.
    cyc(0, 0, 0, 1, 5'd7, 0, E_MC, "mc7_entry");
    cyc(0, 0, 0, 1, 5'd7, 0, E_MC, "mc7_wait");
    cyc(1, 0, 0, 1, 5'd7, 0, E_RST, "mc7_reset");
    cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "post_reset_run");
    cyc(0, 1, 0, 0, 5'd0, 0, E_HAZ, "post_reset_hazard");

    // Redirect arriving during a multi-cycle wait is ignored until release.
    cyc(0, 0, 0, 1, 5'd2, 0, E_MC, "mc2_entry");
    cyc(0, 0, 1, 1, 5'd2, 0, E_REDIR, "mc2_release_redirect");
    cyc(0, 0, 0, 0, 5'd0, 0, E_DEF, "mc2_run");

    for (int i = 0; i < 600; i++) begin
      logic r, ldh, red, mcs, mem;
      logic [4:0] lat;
      r   = ($urandom_range(0, 49) == 0);
      ldh = ($urandom_range(0, 3) == 0);
      red = ($urandom_range(0, 5) == 0);
      mcs = ($urandom_range(0, 5) == 0);
      lat = 5'($urandom_range(0, 7));
      mem = ($urandom_range(0, 6) == 0);
      cyc(r, ldh, red, mcs, lat, mem, model_exp(r, ldh, red, mcs, lat, mem), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
